// File: rtl/data_memory_ctrl.sv
// Byte-addressed data memory for the MEM stage with a req/ack handshake,
// programmable wait states, sized loads/stores and alignment/range rejection.
module data_memory_ctrl #(
  parameter int DEPTH_BYTES = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        Clock_i,
  input  logic        Reset_n_i,
  input  logic        Req_i,
  input  logic        MemWrite_i,
  input  logic [1:0]  Size_i,
  input  logic        Unsigned_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic        Ack_o,
  output logic        Err_o,
  output logic        Busy_o,
  output logic [31:0] data_o
);

  localparam int AW = $clog2(DEPTH_BYTES);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [7:0]    mem [DEPTH_BYTES];
  logic [1:0]    state_r;
  logic [CW-1:0] cnt_r;
  logic [AW-1:0] addr_r;
  logic [31:0]   data_r;
  logic [1:0]    size_r;
  logic          wr_r;
  logic          uns_r;

  logic [2:0]    nbytes_s;
  logic          illegal_s;
  logic [32:0]   end_s;
  logic          access_s;
  logic [3:0]    be_s;
  logic [31:0]   rd_s;
  logic [31:0]   load_s;

  // Request legality: size code, natural alignment and upper bound of the span.
  always_comb begin
    nbytes_s  = 3'd4;
    illegal_s = 1'b0;
    case (Size_i)
      2'b00: nbytes_s = 3'd1;
      2'b01: begin
        nbytes_s = 3'd2;
        if (addr_i[0]) illegal_s = 1'b1;
        else illegal_s = 1'b0;
      end
      2'b10: begin
        nbytes_s = 3'd4;
        if (addr_i[1:0] != 2'b00) illegal_s = 1'b1;
        else illegal_s = 1'b0;
      end
      default: begin
        nbytes_s  = 3'd4;
        illegal_s = 1'b1;
      end
    endcase
    end_s = {1'b0, addr_i} + 33'(nbytes_s);
    if (end_s > 33'(DEPTH_BYTES)) illegal_s = 1'b1;
    else illegal_s = illegal_s;
  end

  assign access_s = (state_r == WAIT) && (cnt_r == {CW{1'b0}});

  // Little-endian gather of the captured span, then sign/zero extension by size.
  always_comb begin
    rd_s = {mem[addr_r + AW'(3)], mem[addr_r + AW'(2)],
            mem[addr_r + AW'(1)], mem[addr_r]};
    case (size_r)
      2'b00: begin
        be_s = 4'b0001;
        if (uns_r) load_s = {24'd0, rd_s[7:0]};
        else load_s = {{24{rd_s[7]}}, rd_s[7:0]};
      end
      2'b01: begin
        be_s = 4'b0011;
        if (uns_r) load_s = {16'd0, rd_s[15:0]};
        else load_s = {{16{rd_s[15]}}, rd_s[15:0]};
      end
      default: begin
        be_s   = 4'b1111;
        load_s = rd_s;
      end
    endcase
  end

  // Storage array: contents survive reset, but a reset on the access edge suppresses the write.
  always_ff @(posedge Clock_i) begin
    if (Reset_n_i && access_s && wr_r) begin
      for (int i = 0; i < 4; i++) begin
        if (be_s[i]) mem[addr_r + AW'(i)] <= data_r[8*i +: 8];
      end
    end
  end

  // Handshake FSM with registered Ack/Err/Busy and load result.
  always_ff @(posedge Clock_i) begin
    if (!Reset_n_i) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
      addr_r  <= {AW{1'b0}};
      data_r  <= 32'd0;
      size_r  <= 2'b00;
      wr_r    <= 1'b0;
      uns_r   <= 1'b0;
      Ack_o   <= 1'b0;
      Err_o   <= 1'b0;
      Busy_o  <= 1'b0;
      data_o  <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (Req_i) begin
            addr_r <= addr_i[AW-1:0];
            data_r <= data_i;
            size_r <= Size_i;
            wr_r   <= MemWrite_i;
            uns_r  <= Unsigned_i;
            Busy_o <= 1'b1;
            if (illegal_s) begin
              state_r <= DONE;
              Ack_o   <= 1'b1;
              Err_o   <= 1'b1;
              data_o  <= 32'd0;
            end else begin
              state_r <= WAIT;
              cnt_r   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt_r != {CW{1'b0}}) begin
            cnt_r <= cnt_r - CW'(1);
          end else begin
            state_r <= DONE;
            Ack_o   <= 1'b1;
            Err_o   <= 1'b0;
            if (!wr_r) data_o <= load_s;
          end
        end
        DONE: begin
          state_r <= IDLE;
          Ack_o   <= 1'b0;
          Err_o   <= 1'b0;
          Busy_o  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          Ack_o   <= 1'b0;
          Err_o   <= 1'b0;
          Busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Self-checking bench: byte-array reference model, directed scenarios and random accesses.
module tb_data_memory_ctrl;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        rst_n, req, wr, uns, ack, err, busy;
  logic [1:0]  size;
  logic [31:0] addr, wdata, rdata;

  logic        rst1_n, req1, wr1, uns1, ack1, err1, busy1;
  logic [1:0]  size1;
  logic [31:0] addr1, wdata1, rdata1;

  int errors = 0;
  int checks = 0;

  logic [7:0]  model_mem [DEPTH];
  logic [31:0] exp_data = 32'd0;

  always #5 clk = ~clk;

  data_memory_ctrl #(.DEPTH_BYTES(DEPTH), .LATENCY(LAT)) u_dut (
    .Clock_i(clk), .Reset_n_i(rst_n), .Req_i(req), .MemWrite_i(wr), .Size_i(size),
    .Unsigned_i(uns), .addr_i(addr), .data_i(wdata), .Ack_o(ack), .Err_o(err),
    .Busy_o(busy), .data_o(rdata)
  );

  data_memory_ctrl #(.DEPTH_BYTES(64), .LATENCY(1)) u_dut_lat1 (
    .Clock_i(clk), .Reset_n_i(rst1_n), .Req_i(req1), .MemWrite_i(wr1), .Size_i(size1),
    .Unsigned_i(uns1), .addr_i(addr1), .data_i(wdata1), .Ack_o(ack1), .Err_o(err1),
    .Busy_o(busy1), .data_o(rdata1)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int size_bytes(input logic [1:0] s);
    if (s == 2'd0) return 1;
    if (s == 2'd1) return 2;
    return 4;
  endfunction

  function automatic bit is_legal(input logic [1:0] s, input logic [31:0] a);
    int n;
    if (s == 2'd3) return 1'b0;
    n = size_bytes(s);
    if ((longint'(a) % n) != 0) return 1'b0;
    if (longint'(a) + n > DEPTH) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] s, input bit u, input logic [31:0] a);
    longint v = 0;
    int n = size_bytes(s);
    for (int i = 0; i < n; i++) v += longint'(model_mem[a + i]) << (8 * i);
    if (!u && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  // One complete transaction: drive, measure Ack latency, compare against the model.
  task automatic access(input bit w, input logic [1:0] s, input bit u,
                        input logic [31:0] a, input logic [31:0] d, input string tag);
    int n;
    bit legal;
    @(negedge clk);
    req = 1'b1; wr = w; size = s; uns = u; addr = a; wdata = d;
    @(posedge clk); #1;
    req = 1'b0;
    legal = is_legal(s, a);
    check_eq({tag, " busy"}, {31'd0, busy}, 32'd1);
    n = 0;
    while (!ack && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq({tag, " latency"}, n, legal ? LAT : 0);
    check_eq({tag, " err"}, {31'd0, err}, {31'd0, !legal});
    if (!legal) exp_data = 32'd0;
    else if (w) for (int i = 0; i < size_bytes(s); i++) model_mem[a + i] = d[8*i +: 8];
    else exp_data = model_load(s, u, a);
    check_eq({tag, " data"}, rdata, exp_data);
    @(posedge clk); #1;
    check_eq({tag, " ack drop"}, {31'd0, ack}, 32'd0);
    check_eq({tag, " idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [31:0] ra;
    logic [1:0]  rs;
    bit ack_h [24];
    bit busy_h [24];
    int ack_idx [$];
    int lows;

    rst_n = 1'b0; req = 1'b0; wr = 1'b0; size = 2'd0; uns = 1'b0; addr = 32'd0; wdata = 32'd0;
    rst1_n = 1'b0; req1 = 1'b0; wr1 = 1'b0; size1 = 2'd0; uns1 = 1'b0; addr1 = 32'd0; wdata1 = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset outputs", {ack, err, busy, rdata[28:0]}, 32'd0);
    check_eq("reset data", rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; rst1_n = 1'b1;

    for (int a = 0; a < 128; a += 4) access(1'b1, 2'd2, 1'b0, a, $urandom, "init");
    access(1'b1, 2'd2, 1'b0, DEPTH - 8, $urandom, "init top");
    access(1'b1, 2'd2, 1'b0, DEPTH - 4, $urandom, "init top");

    access(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, "t1 store");
    access(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, "t1 load");
    check_eq("t1 value", rdata, 32'hDEADBEEF);

    access(1'b1, 2'd0, 1'b0, 32'h11, 32'h00000080, "t2 store");
    access(1'b0, 2'd0, 1'b0, 32'h11, 32'd0, "t2 lbs");
    check_eq("t2 lbs value", rdata, 32'hFFFFFF80);
    access(1'b0, 2'd0, 1'b1, 32'h11, 32'd0, "t2 lbu");
    check_eq("t2 lbu value", rdata, 32'h00000080);
    access(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, "t2 lw");
    check_eq("t2 lw value", rdata, 32'hDEAD80EF);

    access(1'b0, 2'd1, 1'b0, 32'h13, 32'd0, "t3 half misaligned");
    access(1'b0, 2'd2, 1'b0, DEPTH, 32'd0, "t3 word range");
    access(1'b0, 2'd3, 1'b0, 32'h10, 32'd0, "t3 size11");
    access(1'b1, 2'd2, 1'b0, 32'h12, 32'hCAFEF00D, "t3 bad store");
    access(1'b1, 2'd1, 1'b0, DEPTH - 1, 32'hCAFEF00D, "t3 range store");
    access(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, "t3 unchanged");
    check_eq("t3 unchanged value", rdata, 32'hDEAD80EF);

    // Reset lands on the edge where the store would be performed.
    @(negedge clk);
    req = 1'b1; wr = 1'b1; size = 2'd2; uns = 1'b0; addr = 32'h20; wdata = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    repeat (LAT - 1) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_eq("t4 ack", {31'd0, ack}, 32'd0);
    check_eq("t4 outputs", {29'd0, ack, err, busy}, 32'd0);
    check_eq("t4 data", rdata, 32'd0);
    exp_data = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    access(1'b0, 2'd2, 1'b0, 32'h20, 32'd0, "t4 load");

    access(1'b1, 2'd2, 1'b0, 32'h30, 32'h11223344, "t6 init");
    access(1'b1, 2'd1, 1'b0, 32'h30, 32'hFFFFABCD, "t6 half");
    access(1'b0, 2'd2, 1'b0, 32'h30, 32'd0, "t6 load");
    check_eq("t6 value", rdata, 32'h1122ABCD);

    for (int k = 0; k < 80; k++) begin
      rs = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) ra = DEPTH - 8 + $urandom_range(0, 11);
      else ra = $urandom_range(0, 127);
      if ($urandom_range(0, 1) == 1 && rs != 2'd3) ra = ra & ~(size_bytes(rs) - 1);
      access(1'($urandom_range(0, 1)), rs, 1'($urandom_range(0, 1)), ra, $urandom, "rand");
    end

    // Throughput with LATENCY=1 and a permanently asserted request.
    @(negedge clk);
    req1 = 1'b1; wr1 = 1'b1; size1 = 2'd2; addr1 = 32'd4; wdata1 = 32'hA5A5A5A5;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      ack_h[i] = ack1;
      busy_h[i] = busy1;
      if (ack1) ack_idx.push_back(i);
    end
    req1 = 1'b0;
    check_eq("t5 pulse count", (ack_idx.size() >= 6) ? 32'd1 : 32'd0, 32'd1);
    for (int j = 1; j < ack_idx.size(); j++) begin
      check_eq("t5 period", ack_idx[j] - ack_idx[j-1], 32'd3);
      lows = 0;
      for (int i = ack_idx[j-1] + 1; i < ack_idx[j]; i++) if (!busy_h[i]) lows++;
      check_eq("t5 busy low", lows, 32'd1);
      check_eq("t5 err", {31'd0, err1}, 32'd0);
    end
    check_eq("t5 ack busy", {31'd0, busy_h[ack_idx.size() > 0 ? ack_idx[0] : 0]}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
